// File: rtl/frac_det_ctrl_if.sv
// Control/status bundle between the SDI RX rate controller and its surroundings.
// The slave side is the controller; the master side drives mode, enable and the
// raw detector verdicts and observes the detector controls and the lock status.
interface frac_det_ctrl_if;
   logic       enable;
   logic       rx_tg_hdn;
   logic       det_valid;
   logic       det_frac;
   logic       det_rstn;
   logic       det_ce;
   logic       frac_intn;
   logic       rate_locked;
   logic       rate_change;
   logic       acq_timeout;
   logic [1:0] state;

   modport master (
      output enable,
      output rx_tg_hdn,
      output det_valid,
      output det_frac,
      input  det_rstn,
      input  det_ce,
      input  frac_intn,
      input  rate_locked,
      input  rate_change,
      input  acq_timeout,
      input  state
   );

   modport slave (
      input  enable,
      input  rx_tg_hdn,
      input  det_valid,
      input  det_frac,
      output det_rstn,
      output det_ce,
      output frac_intn,
      output rate_locked,
      output rate_change,
      output acq_timeout,
      output state
   );
endinterface

// File: rtl/frac_det_ctrl.sv
// Fractional-rate detector sequencer: re-arms the detector, samples its verdict once per
// measurement window (mid-window), debounces it into a locked integer/fractional decision
// and drops lock on repeated disagreement, mode change or acquisition timeout.
module frac_det_ctrl #(
   parameter int unsigned Win     = 148350, // ref_clk cycles per measurement window
   parameter int unsigned RstCyc  = 8,      // cycles the detector is held in reset per re-arm
   parameter int unsigned Confirm = 4,      // identical valid verdicts needed to lock (1..15)
   parameter int unsigned Loss    = 2,      // bad verdicts in a row that drop lock (1..15)
   parameter int unsigned MaxWin  = 16      // counted windows allowed in acquire (1..255)
) (
   input logic            ref_clk_i,
   input logic            rst_i,
   frac_det_ctrl_if.slave bus_io
);

   localparam int unsigned WcntW = (Win > 1) ? $clog2(Win) : 1;
   localparam int unsigned RcntW = $clog2(RstCyc + 1);

   localparam logic [WcntW-1:0] WrapAt    = WcntW'(Win - 1);
   localparam logic [WcntW-1:0] StrobeAt  = WcntW'(Win / 2 - 1);
   localparam logic [RcntW-1:0] RearmLast = RcntW'(RstCyc - 1);
   localparam logic [3:0]       ConfLim   = 4'(Confirm);
   localparam logic [3:0]       LossLim   = 4'(Loss);
   localparam logic [7:0]       NwinLim   = 8'(MaxWin);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StRearm   = 2'b01,
      StAcquire = 2'b10,
      StLocked  = 2'b11
   } state_e;

   state_e           state_q;
   logic [RcntW-1:0] rcnt_q;
   logic [WcntW-1:0] wcnt_q;
   logic             first_q;
   logic             have_cand_q;
   logic             cand_q;
   logic [3:0]       conf_q;
   logic [3:0]       loss_q;
   logic [7:0]       nwin_q;
   logic             det_rstn_q;
   logic             det_ce_q;
   logic             frac_intn_q;
   logic             rate_locked_q;
   logic             rate_change_q;
   logic             acq_timeout_q;
   logic             mode_q;
   logic             valid_s1_q, valid_s2_q;
   logic             frac_s1_q, frac_s2_q;

   logic             cand_d;
   logic [3:0]       conf_d;
   logic [3:0]       loss_d;
   logic [7:0]       nwin_d;
   logic [WcntW-1:0] wcnt_d;
   logic             strobe;
   logic             sample;
   logic             mode_chg;
   logic             flip;
   logic             lock_hit;
   logic             loss_drop;
   logic             acq_expire;
   logic             rearm;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Two-flop synchronisers for the rec_clk verdicts, plus the registered mode copy.
   always_ff @(posedge ref_clk_i) begin
      if (rst_i) begin
         valid_s1_q <= 1'b0;
         valid_s2_q <= 1'b0;
         frac_s1_q  <= 1'b0;
         frac_s2_q  <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         valid_s1_q <= bus_io.det_valid;
         valid_s2_q <= valid_s1_q;
         frac_s1_q  <= bus_io.det_frac;
         frac_s2_q  <= frac_s1_q;
         mode_q     <= bus_io.rx_tg_hdn;
      end
   end

   // Sample-time next values and the decisions that hang off them.
   always_comb begin
      cand_d = cand_q;
      conf_d = conf_q;
      if (!valid_s2_q) begin
         conf_d = 4'd0;
      end else if (!have_cand_q || (frac_s2_q != cand_q)) begin
         cand_d = frac_s2_q;
         conf_d = 4'd1;
      end else begin
         conf_d = sat_inc4(conf_q);
      end

      nwin_d = sat_inc8(nwin_q);
      flip   = valid_s2_q && (frac_s2_q != frac_intn_q);
      loss_d = (valid_s2_q && !flip) ? 4'd0 : sat_inc4(loss_q);
      wcnt_d = (wcnt_q == WrapAt) ? '0 : wcnt_q + WcntW'(1);

      strobe   = ((state_q == StAcquire) || (state_q == StLocked)) && (wcnt_q == StrobeAt);
      // The first strobe after a re-arm covers a partial window and is thrown away.
      sample   = strobe && !first_q;
      mode_chg = bus_io.rx_tg_hdn != mode_q;
      lock_hit = (conf_d == ConfLim);

      // Lock beats timeout on the same strobe; a mode change beats both.
      acq_expire = (state_q == StAcquire) && sample && !lock_hit && (nwin_d == NwinLim) &&
                   !mode_chg;
      loss_drop  = (state_q == StLocked) && sample && (loss_d == LossLim) && !mode_chg;
      rearm      = (state_q == StIdle) || mode_chg || acq_expire || loss_drop;
   end

   // Main sequencer with registered detector controls, status and pulses.
   always_ff @(posedge ref_clk_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         rcnt_q        <= '0;
         wcnt_q        <= '0;
         first_q       <= 1'b0;
         have_cand_q   <= 1'b0;
         cand_q        <= 1'b0;
         conf_q        <= '0;
         loss_q        <= '0;
         nwin_q        <= '0;
         det_rstn_q    <= 1'b0;
         det_ce_q      <= 1'b0;
         frac_intn_q   <= 1'b0;
         rate_locked_q <= 1'b0;
         rate_change_q <= 1'b0;
         acq_timeout_q <= 1'b0;
      end else begin
         rate_change_q <= 1'b0;
         acq_timeout_q <= 1'b0;
         if (!bus_io.enable) begin
            state_q       <= StIdle;
            det_rstn_q    <= 1'b0;
            det_ce_q      <= 1'b0;
            rate_locked_q <= 1'b0;
         end else if (rearm) begin
            state_q       <= StRearm;
            rcnt_q        <= '0;
            wcnt_q        <= '0;
            first_q       <= 1'b1;
            have_cand_q   <= 1'b0;
            conf_q        <= '0;
            loss_q        <= '0;
            nwin_q        <= '0;
            det_rstn_q    <= 1'b0;
            det_ce_q      <= 1'b0;
            rate_locked_q <= 1'b0;
            // Only a genuine verdict flip is reported, not a run of invalid windows.
            rate_change_q <= loss_drop && flip;
            acq_timeout_q <= acq_expire;
         end else begin
            unique case (state_q)
               StRearm: begin
                  if (rcnt_q == RearmLast) begin
                     state_q    <= StAcquire;
                     det_rstn_q <= 1'b1;
                     det_ce_q   <= 1'b1;
                  end else begin
                     rcnt_q <= rcnt_q + RcntW'(1);
                  end
               end
               StAcquire: begin
                  wcnt_q <= wcnt_d;
                  if (strobe) first_q <= 1'b0;
                  if (sample) begin
                     cand_q <= cand_d;
                     conf_q <= conf_d;
                     nwin_q <= nwin_d;
                     if (valid_s2_q) have_cand_q <= 1'b1;
                     if (lock_hit) begin
                        state_q       <= StLocked;
                        frac_intn_q   <= cand_d;
                        rate_locked_q <= 1'b1;
                        loss_q        <= '0;
                     end
                  end
               end
               StLocked: begin
                  wcnt_q <= wcnt_d;
                  if (sample) loss_q <= loss_d;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus_io.det_rstn    = det_rstn_q;
   assign bus_io.det_ce      = det_ce_q;
   assign bus_io.frac_intn   = frac_intn_q;
   assign bus_io.rate_locked = rate_locked_q;
   assign bus_io.rate_change = rate_change_q;
   assign bus_io.acq_timeout = acq_timeout_q;
   assign bus_io.state       = state_q;

endmodule

// File: tb/tb_frac_det_ctrl.sv
// Bench for frac_det_ctrl: expected output events (det_ce rise, lock, unlock, pulses) are
// queued with their expected cycle when stimulus is applied and matched as they appear.
module tb_frac_det_ctrl;

   localparam int EvCeRise  = 1;
   localparam int EvLock    = 2;
   localparam int EvUnlock  = 3;
   localparam int EvChange  = 4;
   localparam int EvTimeout = 5;

   typedef struct {
      int   kind;
      int   cyc;
      logic frac;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  sb_q[$];
   logic prev_lock = 1'b0;
   logic prev_ce = 1'b0;

   frac_det_ctrl_if bus ();

   frac_det_ctrl #(
      .Win    (100),
      .RstCyc (8),
      .Confirm(4),
      .Loss   (2),
      .MaxWin (6)
   ) dut (
      .ref_clk_i(clk),
      .rst_i    (rst),
      .bus_io   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic sb_push(input int kind, input int at, input logic frac);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      e.frac = frac;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind);
      ev_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_unexpected_ev", kind, 0);
      end else begin
         e = sb_q.pop_front();
         check_val("sb_kind", kind, e.kind);
         check_val("sb_cyc", cyc, e.cyc);
         if (kind == EvLock) check_val("sb_lock_frac", bus.frac_intn, e.frac);
      end
   endtask

   // Event monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.acq_timeout === 1'b1) sb_pop(EvTimeout);
      if (bus.rate_change === 1'b1) sb_pop(EvChange);
      if (prev_lock === 1'b1 && bus.rate_locked !== 1'b1) sb_pop(EvUnlock);
      if (prev_lock !== 1'b1 && bus.rate_locked === 1'b1) sb_pop(EvLock);
      if (prev_ce !== 1'b1 && bus.det_ce === 1'b1) sb_pop(EvCeRise);
      prev_lock = bus.rate_locked;
      prev_ce   = bus.det_ce;
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
      check_val("sched", cyc, c);
   endtask

   // Reset, load verdict inputs, raise enable; r is the edge that enters REARM.
   task automatic start_run(input logic v, input logic f, output int r);
      bus.enable = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.det_valid = v;
      bus.det_frac  = f;
      @(negedge clk);
      bus.enable = 1'b1;
      r = cyc + 1;
      sb_push(EvCeRise, r + 8, 1'b0);
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_state"}, bus.state, 0);
      check_val({tag, "_rstn"}, bus.det_rstn, 0);
      check_val({tag, "_ce"}, bus.det_ce, 0);
      check_val({tag, "_locked"}, bus.rate_locked, 0);
      check_val({tag, "_chg"}, bus.rate_change, 0);
      check_val({tag, "_tmo"}, bus.acq_timeout, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int r, r2, l, m, n;
      rst = 1'b1;
      bus.enable    = 1'b0;
      bus.rx_tg_hdn = 1'b0;
      bus.det_valid = 1'b0;
      bus.det_frac  = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check_val("reset_frac", bus.frac_intn, 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_noenable", bus.state, 0);

      // Steady valid fractional verdicts: lock on the 5th strobe.
      start_run(1'b1, 1'b1, r);
      sb_push(EvLock, r + 458, 1'b1);
      wait_until(r + 7);
      check_val("rearm_state", bus.state, 1);
      check_val("rearm_ce", bus.det_ce, 0);
      wait_until(r + 8);
      check_val("acq_state", bus.state, 2);
      check_val("acq_rstn", bus.det_rstn, 1);
      wait_until(r + 458);
      check_val("lock1_state", bus.state, 3);
      check_val("lock1_frac", bus.frac_intn, 1);

      // Verdict flips to integer: unlock with rate_change on the 2nd bad strobe, then relock.
      wait_until(r + 460);
      bus.det_frac = 1'b0;
      r2 = r + 658;
      sb_push(EvChange, r2, 1'b0);
      sb_push(EvUnlock, r2, 1'b0);
      sb_push(EvCeRise, r2 + 8, 1'b0);
      sb_push(EvLock, r2 + 458, 1'b0);
      wait_until(r + 600);
      check_val("loss1_still_locked", bus.rate_locked, 1);
      wait_until(r2);
      check_val("flip_state", bus.state, 1);
      n = 0;
      while (bus.det_rstn === 1'b0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check_val("rstn_low_cycles", n, 8);
      wait_until(r2 + 458);
      check_val("relock_frac", bus.frac_intn, 0);

      // Mode change while locked: immediate re-arm, no pulses; relock to fractional.
      l = r2 + 458;
      wait_until(l + 10);
      bus.rx_tg_hdn = 1'b1;
      bus.det_frac  = 1'b1;
      m = l + 11;
      sb_push(EvUnlock, m, 1'b0);
      sb_push(EvCeRise, m + 8, 1'b0);
      sb_push(EvLock, m + 458, 1'b1);
      wait_until(m);
      check_val("mode_state", bus.state, 1);
      check_val("mode_locked", bus.rate_locked, 0);
      check_val("mode_rstn", bus.det_rstn, 0);
      check_val("mode_chg", bus.rate_change, 0);
      check_val("mode_tmo", bus.acq_timeout, 0);
      check_val("mode_hold_frac", bus.frac_intn, 0);
      wait_until(m + 458);
      check_val("lock3_frac", bus.frac_intn, 1);

      // Reset mid-window while locked, with enable still high.
      wait_until(m + 488);
      rst = 1'b1;
      sb_push(EvUnlock, m + 489, 1'b0);
      @(negedge clk);
      check_idle("rst_locked");
      check_val("rst_locked_frac", bus.frac_intn, 0);
      bus.enable = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_state", bus.state, 0);

      // Drop enable while locked.
      start_run(1'b1, 1'b0, r);
      sb_push(EvLock, r + 458, 1'b0);
      wait_until(r + 478);
      bus.enable = 1'b0;
      sb_push(EvUnlock, r + 479, 1'b0);
      @(negedge clk);
      check_idle("en_drop");

      // No valid verdicts: timeout after discard + 6 strobes, repeatedly.
      start_run(1'b0, 1'b0, r);
      sb_push(EvTimeout, r + 658, 1'b0);
      sb_push(EvCeRise, r + 666, 1'b0);
      sb_push(EvTimeout, r + 1316, 1'b0);
      wait_until(r + 658);
      check_val("tmo_state", bus.state, 1);
      check_val("tmo_locked", bus.rate_locked, 0);
      wait_until(r + 1320);
      bus.enable = 1'b0;

      // Alternating verdicts each window: never confirms, times out.
      start_run(1'b1, 1'b0, r);
      for (int j = 0; j <= 6; j++) begin
         wait_until(r + 8 + 100 * j);
         bus.det_frac = logic'(j % 2);
      end
      sb_push(EvTimeout, r + 658, 1'b0);
      sb_push(EvCeRise, r + 666, 1'b0);
      wait_until(r + 620);
      check_val("alt_state", bus.state, 2);
      check_val("alt_locked", bus.rate_locked, 0);
      wait_until(r + 670);
      bus.enable = 1'b0;

      repeat (5) @(negedge clk);
      check_val("sb_drain", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
